// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: NREQ producers share one FIFO write port,
// with bounded bursts and full/almost_full throttling.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic                    fifo_wr_en,
  output logic [DW-1:0]           fifo_din,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [15:0]             xfer_cnt
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_last_q, rr_last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          wr_en_q, wr_en_d;
  logic [DW-1:0] din_q, din_d;
  logic [15:0]   xfer_q, xfer_d;

  logic          space_ok;
  logic          cur_valid;
  logic [IW-1:0] pick;
  logic          pick_ok;

  // The in-flight write lands one edge later, so almost_full plus a pending
  // write already means no room.
  assign space_ok  = !fifo_full && !(fifo_almost_full && wr_en_q);
  assign cur_valid = req_valid[grant_q];

  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] cand;
    idx     = 0;
    cand    = '0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx  = (32'(rr_last_q) + k) % NREQ;
      cand = IW'(idx);
      if (!pick_ok && req_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    burst_d   = burst_q;
    wr_en_d   = 1'b0;
    din_d     = din_q;
    xfer_d    = xfer_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_q] = space_ok;
        if (!cur_valid) begin
          state_d   = IDLE;
          rr_last_d = grant_q;
        end else if (!space_ok) begin
          state_d = WAIT;
        end else begin
          wr_en_d = 1'b1;
          din_d   = req_data[grant_q*DW +: DW];
          burst_d = burst_q + 1'b1;
          xfer_d  = xfer_q + 16'd1;
          if (burst_q == BW'(BURST - 1)) begin
            state_d   = IDLE;
            rr_last_d = grant_q;
          end
        end
      end
      WAIT: begin
        if (!cur_valid) begin
          state_d   = IDLE;
          rr_last_d = grant_q;
        end else if (space_ok) begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= IW'(NREQ - 1);
      burst_q   <= '0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
      xfer_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      burst_q   <= burst_d;
      wr_en_q   <= wr_en_d;
      din_q     <= din_d;
      xfer_q    <= xfer_d;
    end
  end

  assign fifo_wr_en  = wr_en_q;
  assign fifo_din    = din_q;
  assign grant_valid = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign xfer_cnt    = xfer_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with behavioural producers and a
// 16-deep FIFO occupancy model driving the full/almost_full flags.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] xfer_cnt;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .grant_valid      (grant_valid),
    .grant_id         (grant_id),
    .xfer_cnt         (xfer_cnt)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_bad = 0;
  int         n_left[4];
  logic [7:0] nxt[4];
  logic [7:0] inc[4];
  int         cnt;
  bit         rd_each;
  int         rd_once;
  int         ovf, viol, saw_rdy, cyc_no;
  logic       gv_prev;
  int         wq[$], wcyc[$], gq[$], gcyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (n_left[i] > 0);
      req_data[i*8 +: 8]  = nxt[i];
    end
    fifo_full        = (cnt == 16);
    fifo_almost_full = (cnt == 15);
  endtask

  task automatic clear_bench();
    for (int i = 0; i < 4; i++) begin
      n_left[i] = 0;
      nxt[i]    = 8'h00;
      inc[i]    = 8'h00;
    end
    cnt = 0; rd_each = 0; rd_once = 0;
    ovf = 0; viol = 0; saw_rdy = 0; cyc_no = 0;
    gv_prev = 1'b0;
    wq.delete(); wcyc.delete(); gq.delete(); gcyc.delete();
  endtask

  task automatic step();
    logic [3:0] hs;
    logic       wr;
    bit         rd, rdok, wok;
    @(negedge clk);
    hs = req_valid & req_ready;
    wr = fifo_wr_en;
    if (wr) begin
      wq.push_back(int'(fifo_din));
      wcyc.push_back(cyc_no);
    end
    if (grant_valid && !gv_prev) begin
      gq.push_back(int'(grant_id));
      gcyc.push_back(cyc_no);
    end
    gv_prev = grant_valid;
    if (req_ready[0]) saw_rdy++;
    if (req_ready[0] && (fifo_full || (fifo_almost_full && fifo_wr_en))) viol++;
    rd = rd_each || (rd_once > 0);
    @(posedge clk);
    #1;
    rdok = rd && (cnt > 0);
    wok  = wr && (cnt < 16);
    if (wr && cnt >= 16) ovf++;
    cnt = cnt + int'(wok) - int'(rdok);
    if (rd_once > 0) rd_once--;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        n_left[i]--;
        nxt[i] = nxt[i] + inc[i];
      end
    end
    cyc_no++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    clear_bench();
    drive_inputs();
  endtask

  task automatic release_reset();
    drive_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_bench();
    drive_inputs();
    // Async reset asserted before any clock edge.
    #1 rst = 1'b0;
    #1;
    check_eq("rst_wr_en", fifo_wr_en, 0);
    check_eq("rst_din", fifo_din, 0);
    check_eq("rst_gv", grant_valid, 0);
    check_eq("rst_gid", grant_id, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_xfer", xfer_cnt, 0);

    // Single requester 2, 8 words, burst of 4 then a one-cycle bubble.
    n_left[2] = 8; nxt[2] = 8'h10; inc[2] = 8'h01;
    release_reset();
    run(14);
    check_eq("t1_nwr", wq.size(), 8);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("t1_data%0d", k), qget(wq, k), 32'h10 + k);
    check_eq("t1_burst_a", qget(wcyc, 3) - qget(wcyc, 0), 3);
    check_eq("t1_bubble", qget(wcyc, 4) - qget(wcyc, 3), 2);
    check_eq("t1_burst_b", qget(wcyc, 7) - qget(wcyc, 4), 3);
    check_eq("t1_ngrant", gq.size(), 2);
    check_eq("t1_gid", qget(gq, 0), 2);
    check_eq("t1_xfer", xfer_cnt, 8);
    check_eq("t1_fifo", cnt, 8);

    // All four requesters valid, FIFO drained every cycle.
    enter_reset();
    for (int i = 0; i < 4; i++) begin
      n_left[i] = 8; nxt[i] = 8'hA0 + 8'(i);
    end
    rd_each = 1;
    release_reset();
    run(45);
    check_eq("t2_nwr", wq.size(), 32);
    for (int k = 0; k < 32; k++)
      check_eq($sformatf("t2_data%0d", k), qget(wq, k), 32'hA0 + ((k / 4) % 4));
    check_eq("t2_ngrant", gq.size(), 8);
    for (int j = 0; j < 8; j++)
      check_eq($sformatf("t2_order%0d", j), qget(gq, j), j % 4);
    check_eq("t2_wait3", qget(gcyc, 3), 15);
    check_eq("t2_xfer", xfer_cnt, 32);
    check_eq("t2_ovf", ovf, 0);

    // FIFO prefilled to 14, no reads: exactly two writes fit.
    enter_reset();
    cnt = 14;
    n_left[0] = 8; nxt[0] = 8'h30; inc[0] = 8'h01;
    release_reset();
    run(10);
    check_eq("t3_nwr", wq.size(), 2);
    check_eq("t3_w0", qget(wq, 0), 32'h30);
    check_eq("t3_w1", qget(wq, 1), 32'h31);
    check_eq("t3_fifo", cnt, 16);
    check_eq("t3_ovf", ovf, 0);
    check_eq("t3_viol", viol, 0);
    check_eq("t3_gv", grant_valid, 1);
    check_eq("t3_ready", req_ready, 0);
    check_eq("t3_xfer", xfer_cnt, 2);

    // One read while waiting at full lets exactly one more word in.
    wq.delete();
    saw_rdy = 0;
    rd_once = 1;
    run(8);
    check_eq("t4_nwr", wq.size(), 1);
    check_eq("t4_w0", qget(wq, 0), 32'h32);
    check_eq("t4_fifo", cnt, 16);
    check_eq("t4_ovf", ovf, 0);
    check_eq("t4_viol", viol, 0);
    check_eq("t4_sawrdy", saw_rdy > 0, 1);
    check_eq("t4_xfer", xfer_cnt, 3);

    // Requester 1 drops valid after two words; requester 3 is next.
    enter_reset();
    n_left[1] = 2; nxt[1] = 8'hB0; inc[1] = 8'h01;
    n_left[3] = 4; nxt[3] = 8'hD0; inc[3] = 8'h01;
    rd_each = 1;
    release_reset();
    run(14);
    check_eq("t5_ngrant", gq.size(), 2);
    check_eq("t5_g0", qget(gq, 0), 1);
    check_eq("t5_g1", qget(gq, 1), 3);
    check_eq("t5_g1cyc", qget(gcyc, 1), 4);
    check_eq("t5_nwr", wq.size(), 6);
    check_eq("t5_w1", qget(wq, 1), 32'hB1);
    check_eq("t5_w2", qget(wq, 2), 32'hD0);
    check_eq("t5_w5", qget(wq, 5), 32'hD3);
    check_eq("t5_xfer", xfer_cnt, 6);

    // Reset mid-burst while a write is in flight.
    enter_reset();
    n_left[0] = 4; nxt[0] = 8'hE0; inc[0] = 8'h01;
    n_left[1] = 8; nxt[1] = 8'hF0; inc[1] = 8'h01;
    rd_each = 1;
    release_reset();
    run(8);
    check_eq("t6_pre_nwr", wq.size(), 6);
    check_eq("t6_pre_gid", grant_id, 1);
    check_eq("t6_pre_wr", fifo_wr_en, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_wr_en", fifo_wr_en, 0);
    check_eq("t6_din", fifo_din, 0);
    check_eq("t6_gv", grant_valid, 0);
    check_eq("t6_gid", grant_id, 0);
    check_eq("t6_ready", req_ready, 0);
    check_eq("t6_xfer", xfer_cnt, 0);
    clear_bench();
    n_left[0] = 3; nxt[0] = 8'h50; inc[0] = 8'h01;
    n_left[1] = 3; nxt[1] = 8'h60; inc[1] = 8'h01;
    rd_each = 1;
    release_reset();
    run(2);
    check_eq("t6_first_gid", qget(gq, 0), 0);
    check_eq("t6_nwr", wq.size(), 1);
    check_eq("t6_w0", qget(wq, 0), 32'h50);
    check_eq("t6_xfer_after", xfer_cnt, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
